// File: rtl/pla_pkg.sv
// Shared code-word definitions and the decode table used by the PLA encoder and decoder.
`timescale 1ns/1ps
package pla_pkg;

  localparam int CODE_W  = 4;
  localparam int XYZ_W   = 3;
  localparam int ENTRY_W = XYZ_W + 2;

  // Code words {A,B,C,D}; the name gives the xyz value each one decodes to.
  localparam logic [CODE_W-1:0] CODE_XYZ_000 = 4'b0100;
  localparam logic [CODE_W-1:0] CODE_XYZ_001 = 4'b1101;
  localparam logic [CODE_W-1:0] CODE_XYZ_010 = 4'b0001;
  localparam logic [CODE_W-1:0] CODE_XYZ_011 = 4'b1010;
  localparam logic [CODE_W-1:0] CODE_XYZ_101 = 4'b1011;
  localparam logic [CODE_W-1:0] CODE_XYZ_110 = 4'b1100;
  localparam logic [CODE_W-1:0] CODE_XYZ_111 = 4'b0101;
  // xyz 010 and 100 both encode to this word; the decoder reports 010.
  localparam logic [CODE_W-1:0] CODE_AMB     = CODE_XYZ_010;

  typedef struct packed {
    logic [XYZ_W-1:0] xyz;
    logic             amb;
    logic             err;
  } result_t;

  function automatic result_t decode_code(input logic [CODE_W-1:0] code);
    result_t r;
    r = '{xyz: 3'b000, amb: 1'b0, err: 1'b0};
    unique case (code)
      CODE_XYZ_000: r.xyz = 3'b000;
      CODE_XYZ_001: r.xyz = 3'b001;
      CODE_AMB:     begin r.xyz = 3'b010; r.amb = 1'b1; end
      CODE_XYZ_011: r.xyz = 3'b011;
      CODE_XYZ_101: r.xyz = 3'b101;
      CODE_XYZ_110: r.xyz = 3'b110;
      CODE_XYZ_111: r.xyz = 3'b111;
      default:      r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pla_fifo.sv
// Result buffer between the decoder and its consumer: DEPTH entries, power of two.
`timescale 1ns/1ps
module pla_fifo import pla_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_en) wr_ptr <= wr_ptr + 1'b1;  // power-of-two depth: wraps naturally
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is not reset; an entry is only visible once the count covers it, so reset only needs the pointers and count.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pla_decode.sv
// PLA code-word decoder with a ready/valid result FIFO and optional error counter
// (enabled by defining PLA_DECODE_ERRCNT_EN; otherwise err_cnt is tied to 0).
`timescale 1ns/1ps
module pla_decode import pla_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_i,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [XYZ_W-1:0]  xyz_o,
  output logic              amb_o,
  output logic              err_o,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  result_t dec, head;
  logic    ready_q, full, empty, push, pop;

  // Holds in_ready low through reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign dec       = decode_code(code_i);
  assign in_ready  = ready_q & ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  pla_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (dec),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs read zero while empty so nothing stale shows after reset.
  assign xyz_o = out_valid ? head.xyz : '0;
  assign amb_o = out_valid & head.amb;
  assign err_o = out_valid & head.err;

`ifdef PLA_DECODE_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_cnt_q <= '0;
    else if (err_clr)                       err_cnt_q <= '0;
    else if (push && dec.err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_pla_decode.sv
// Self-checking bench for pla_decode: vector table plus scoreboard of expected results.
`timescale 1ns/1ps
module tb_pla_decode;

`ifdef PLA_DECODE_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] code;
    logic [2:0] xyz;
    logic       amb;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] code_i = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] xyz_o;
  logic       amb_o, err_o, out_valid;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] err_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[16];
  vec_t sb[$];

  pla_decode #(.DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_i    (code_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xyz_o     (xyz_o),
    .amb_o     (amb_o),
    .err_o     (err_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // Scoreboard: inputs are stable at the falling edge, so this sees what the next rising edge does.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("out[%b]", e.code), 32'({xyz_o, amb_o, err_o}), 32'({e.xyz, e.amb, e.err}));
      end
    end
    if (rst_n && in_valid && in_ready) sb.push_back(vecs[code_i]);
  end

  task automatic push_code(input logic [3:0] c);
    int n;
    n = 0;
    code_i = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    // index == code; 0001 is the ambiguous code, unlisted codes are errors
    vecs[0]  = '{4'b0000, 3'b000, 1'b0, 1'b1};
    vecs[1]  = '{4'b0001, 3'b010, 1'b1, 1'b0};
    vecs[2]  = '{4'b0010, 3'b000, 1'b0, 1'b1};
    vecs[3]  = '{4'b0011, 3'b000, 1'b0, 1'b1};
    vecs[4]  = '{4'b0100, 3'b000, 1'b0, 1'b0};
    vecs[5]  = '{4'b0101, 3'b111, 1'b0, 1'b0};
    vecs[6]  = '{4'b0110, 3'b000, 1'b0, 1'b1};
    vecs[7]  = '{4'b0111, 3'b000, 1'b0, 1'b1};
    vecs[8]  = '{4'b1000, 3'b000, 1'b0, 1'b1};
    vecs[9]  = '{4'b1001, 3'b000, 1'b0, 1'b1};
    vecs[10] = '{4'b1010, 3'b011, 1'b0, 1'b0};
    vecs[11] = '{4'b1011, 3'b101, 1'b0, 1'b0};
    vecs[12] = '{4'b1100, 3'b110, 1'b0, 1'b0};
    vecs[13] = '{4'b1101, 3'b001, 1'b0, 1'b0};
    vecs[14] = '{4'b1110, 3'b000, 1'b0, 1'b1};
    vecs[15] = '{4'b1111, 3'b000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({xyz_o, amb_o, err_o}), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single push of 1101, result visible exactly one edge later
    out_ready = 1'b1;
    code_i = 4'b1101;
    in_valid = 1'b1;
    #1 check("lat_pre_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_xyz", 32'({xyz_o, amb_o, err_o}), 32'({3'b001, 1'b0, 1'b0}));
    drain();

    // Full decode table, consumer always ready
    for (int i = 0; i < 16; i++) push_code(vecs[i].code);
    drain();
    check("err_cnt_table", 32'(err_cnt), exp_cnt(9));

    // Back-pressure at DEPTH=2: third push is held until the consumer releases
    out_ready = 1'b0;
    push_code(4'b0100);
    push_code(4'b1010);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'({out_valid, xyz_o}), 32'({1'b1, 3'b000}));
    code_i = 4'b1100;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("held_in_ready", 32'(in_ready), 32'd0);
    check("held_head", 32'({out_valid, xyz_o, err_o}), 32'({1'b1, 3'b000, 1'b0}));
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    drain();
    check("sb_after_backpressure", 32'(sb.size()), 32'd0);

    // Error counter: clear, count, saturate, clear beats increment
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("err_clr", 32'(err_cnt), 32'd0);
    push_code(4'b1111);
    push_code(4'b0000);
    drain();
    check("err_cnt_two", 32'(err_cnt), exp_cnt(2));
    for (int i = 0; i < 253; i++) push_code(4'b1111);
    drain();
    check("err_cnt_255", 32'(err_cnt), exp_cnt(255));
    push_code(4'b0110);
    drain();
    check("err_cnt_sat", 32'(err_cnt), exp_cnt(255));
    code_i = 4'b1111;
    in_valid = 1'b1;
    err_clr = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    err_clr = 1'b0;
    check("clr_priority", 32'(err_cnt), 32'd0);
    drain();

    // Reset with two entries buffered
    out_ready = 1'b0;
    push_code(4'b0101);
    push_code(4'b1011);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_outputs", 32'({xyz_o, amb_o, err_o}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check($sformatf("post_rst_valid[%0d]", i), 32'(out_valid), 32'd0);
    end
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
